// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core: opcode constants, the hazard
// controller state encoding and a small opcode-decode helper.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  typedef enum logic {
    RUN     = 1'b0,
    BR_WAIT = 1'b1
  } hz_state_t;

  // True when the instruction reads rt as a source operand. For I-type ALU
  // ops and lw, rt is the destination, so it can never create a load-use hazard.
  function automatic logic opUsesRt(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_SW) ||
           (opcode == OP_BEQ)   || (opcode == OP_BNE);
  endfunction

  // Conditional branches resolved in EX/MEM.
  function automatic logic opIsBranch(input logic [5:0] opcode);
    return (opcode == OP_BEQ) || (opcode == OP_BNE);
  endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit up counter that sticks at 0xFFFF instead of wrapping, so a long
// debug run never reports a misleadingly small stall count.
module sat_counter16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] count
);

  // Increment on enable until all ones, then hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 16'h0000;
    end else if (en && (count != 16'hFFFF)) begin
      count <= count + 16'h0001;
    end
  end

endmodule

// File: rtl/mips_hazard_ctrl.sv
// Pipeline hazard controller: detects load-use hazards and branches in ID,
// stalls/flushes the front end accordingly, waits for the branch outcome from
// EX/MEM, and keeps saturating stall counters for performance debug.
module mips_hazard_ctrl #(
  parameter int BR_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [5:0]  id_opcode,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        br_resolve,
  input  logic        br_taken,
  output logic        pc_write,
  output logic        pc_sel,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        br_timeout,
  output logic [15:0] lu_stall_cnt,
  output logic [15:0] br_stall_cnt
);

  import mips_pkg::*;

  // wcnt is only 3 bits wide. Comparing against the target modulo 8 still
  // fires on exactly the right cycle for BR_LAT=6 because wcnt wraps 7->0
  // on the eighth wait cycle.
  localparam logic [2:0] TIMEOUT_CNT = 3'((BR_LAT + 2) % 8);

  hz_state_t  state;
  hz_state_t  stateNext;
  logic [2:0] wcnt;
  logic [2:0] wcntNext;
  logic       timeoutSet;
  logic       luInc;
  logic       brInc;
  logic       loadUse;
  logic       branchInId;

  // Hazard terms: a lw in ID/EX whose non-zero destination is read in ID.
  always_comb begin
    loadUse = id_valid && ex_mem_read && (ex_rt != 5'd0) &&
              ((ex_rt == id_rs) || (opUsesRt(id_opcode) && (ex_rt == id_rt)));
    branchInId = id_valid && opIsBranch(id_opcode);
  end

  // Next-state and Mealy control outputs; reset forces a safe front end.
  always_comb begin
    stateNext    = state;
    wcntNext     = wcnt;
    timeoutSet   = 1'b0;
    luInc        = 1'b0;
    brInc        = 1'b0;
    pc_write     = 1'b1;
    pc_sel       = 1'b0;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;

    case (state)
      RUN: begin
        if (loadUse) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          luInc        = 1'b1;
        end else if (branchInId) begin
          pc_write    = 1'b0;
          if_id_flush = 1'b1;
          stateNext   = BR_WAIT;
          wcntNext    = 3'd1;
        end
      end
      BR_WAIT: begin
        if (br_resolve) begin
          pc_write    = 1'b1;
          pc_sel      = br_taken;
          if_id_write = 1'b1;
          if_id_flush = br_taken;
          stateNext   = RUN;
          wcntNext    = 3'd0;
        end else if (wcnt == TIMEOUT_CNT) begin
          pc_write    = 1'b1;
          pc_sel      = 1'b0;
          if_id_flush = 1'b0;
          timeoutSet  = 1'b1;
          stateNext   = RUN;
          wcntNext    = 3'd0;
        end else begin
          pc_write    = 1'b0;
          if_id_flush = 1'b1;
          brInc       = 1'b1;
          wcntNext    = wcnt + 3'd1;
        end
      end
      default: begin
        stateNext = RUN;
        wcntNext  = 3'd0;
      end
    endcase

    if (rst) begin
      pc_write     = 1'b0;
      pc_sel       = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end
  end

  // State register, wait counter and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      wcnt       <= 3'd0;
      br_timeout <= 1'b0;
    end else begin
      state <= stateNext;
      wcnt  <= wcntNext;
      if (timeoutSet) begin
        br_timeout <= 1'b1;
      end
    end
  end

  sat_counter16 luCounter (
    .clk   (clk),
    .rst   (rst),
    .en    (luInc),
    .count (lu_stall_cnt)
  );

  sat_counter16 brCounter (
    .clk   (clk),
    .rst   (rst),
    .en    (brInc),
    .count (br_stall_cnt)
  );

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// Directed bench for mips_hazard_ctrl with BR_LAT=2. Inputs change just after
// the falling edge; outputs are sampled 1 time unit later, away from the
// rising edge where state updates.
module tb_mips_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        br_resolve;
  logic        br_taken;
  logic        pc_write;
  logic        pc_sel;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic        br_timeout;
  logic [15:0] lu_stall_cnt;
  logic [15:0] br_stall_cnt;

  int checks = 0;
  int errors = 0;

  // Control bundle order: {pc_write, pc_sel, if_id_write, if_id_flush, id_ex_bubble}
  localparam logic [4:0] CTRL_RUN   = 5'b10100;
  localparam logic [4:0] CTRL_LU    = 5'b00001;
  localparam logic [4:0] CTRL_FLUSH = 5'b00110;
  localparam logic [4:0] CTRL_TAKEN = 5'b11110;
  localparam logic [4:0] CTRL_RST   = 5'b00011;

  mips_hazard_ctrl #(.BR_LAT(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_opcode    (id_opcode),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .br_resolve   (br_resolve),
    .br_taken     (br_taken),
    .pc_write     (pc_write),
    .pc_sel       (pc_sel),
    .if_id_write  (if_id_write),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble),
    .br_timeout   (br_timeout),
    .lu_stall_cnt (lu_stall_cnt),
    .br_stall_cnt (br_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus: drive after the falling edge, settle, return.
  task automatic applyStimulus(input logic v, input logic [5:0] op,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic mr, input logic [4:0] exRt,
                               input logic res, input logic tk);
    @(negedge clk);
    id_valid    = v;
    id_opcode   = op;
    id_rs       = rs;
    id_rt       = rt;
    ex_mem_read = mr;
    ex_rt       = exRt;
    br_resolve  = res;
    br_taken    = tk;
    #1;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic checkCtrl(input string tag, input logic [4:0] expected);
    checkOutput(tag, {11'd0, pc_write, pc_sel, if_id_write, if_id_flush, id_ex_bubble},
                {11'd0, expected});
  endtask

  initial begin
    rst = 1'b1;
    id_valid = 1'b0; id_opcode = 6'h00; id_rs = 5'd0; id_rt = 5'd0;
    ex_mem_read = 1'b0; ex_rt = 5'd0; br_resolve = 1'b0; br_taken = 1'b0;
    #1;
    checkCtrl("reset_forced_ctrl", CTRL_RST);
    checkOutput("reset_lu_cnt", lu_stall_cnt, 16'd0);
    checkOutput("reset_br_cnt", br_stall_cnt, 16'd0);
    checkOutput("reset_timeout", {15'd0, br_timeout}, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    applyIdle();
    checkCtrl("idle_defaults", CTRL_RUN);

    // Load-use: lw $t0 in ID/EX, add with rs=$t0 in ID.
    applyStimulus(1'b1, 6'h00, 5'd8, 5'd9, 1'b1, 5'd8, 1'b0, 1'b0);
    checkCtrl("lu_add_rs", CTRL_LU);
    applyStimulus(1'b1, 6'h00, 5'd8, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0);
    checkCtrl("lu_after_bubble", CTRL_RUN);
    checkOutput("lu_cnt_1", lu_stall_cnt, 16'd1);

    // ex_rt=0 never stalls, even when rs=0.
    applyStimulus(1'b1, 6'h00, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    checkCtrl("lu_zero_reg", CTRL_RUN);
    // sw with rs matching, rt not matching.
    applyStimulus(1'b1, 6'h2B, 5'd8, 5'd5, 1'b1, 5'd8, 1'b0, 1'b0);
    checkCtrl("lu_sw_rs", CTRL_LU);
    // sw with rt matching (store data is a source).
    applyStimulus(1'b1, 6'h2B, 5'd3, 5'd8, 1'b1, 5'd8, 1'b0, 1'b0);
    checkCtrl("lu_sw_rt", CTRL_LU);
    // addi rt is a destination: no hazard.
    applyStimulus(1'b1, 6'h08, 5'd3, 5'd8, 1'b1, 5'd8, 1'b0, 1'b0);
    checkCtrl("lu_addi_rt", CTRL_RUN);
    // Invalid ID slot: no hazard.
    applyStimulus(1'b0, 6'h00, 5'd8, 5'd8, 1'b1, 5'd8, 1'b0, 1'b0);
    checkCtrl("lu_invalid", CTRL_RUN);
    checkOutput("lu_cnt_3", lu_stall_cnt, 16'd3);

    // Load-use beats branch detection, then branch proceeds.
    applyStimulus(1'b1, 6'h04, 5'd8, 5'd2, 1'b1, 5'd8, 1'b0, 1'b0);
    checkCtrl("lu_over_branch", CTRL_LU);

    // Taken BEQ: t, t+1 wait (br_taken without resolve ignored), t+2 resolve.
    applyStimulus(1'b1, 6'h04, 5'd8, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
    checkCtrl("beq_t", CTRL_FLUSH);
    checkOutput("lu_cnt_4", lu_stall_cnt, 16'd4);
    applyStimulus(1'b0, 6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    checkCtrl("beq_t1", CTRL_FLUSH);
    applyStimulus(1'b0, 6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    checkCtrl("beq_t2_taken", CTRL_TAKEN);
    applyIdle();
    checkCtrl("beq_t3_run", CTRL_RUN);
    checkOutput("br_cnt_1", br_stall_cnt, 16'd1);

    // Not-taken BNE, then a stray resolve in RUN is ignored.
    applyStimulus(1'b1, 6'h05, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
    checkCtrl("bne_t", CTRL_FLUSH);
    applyIdle();
    checkCtrl("bne_t1", CTRL_FLUSH);
    applyStimulus(1'b0, 6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    checkCtrl("bne_t2_not_taken", CTRL_RUN);
    applyStimulus(1'b0, 6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    checkCtrl("resolve_in_run", CTRL_RUN);
    applyIdle();
    checkCtrl("still_run", CTRL_RUN);
    checkOutput("br_cnt_2", br_stall_cnt, 16'd2);

    // Resolve on the timeout cycle (wcnt=4 at t+4): resolve wins.
    applyStimulus(1'b1, 6'h04, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
    applyIdle();
    applyIdle();
    applyIdle();
    checkCtrl("late_t3_wait", CTRL_FLUSH);
    applyStimulus(1'b0, 6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    checkCtrl("late_t4_resolve", CTRL_TAKEN);
    applyIdle();
    checkOutput("late_no_timeout", {15'd0, br_timeout}, 16'd0);
    checkOutput("br_cnt_5", br_stall_cnt, 16'd5);

    // Branch that never resolves: fall through at t+4, sticky timeout.
    applyStimulus(1'b1, 6'h05, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
    applyIdle();
    applyIdle();
    applyIdle();
    checkCtrl("to_t3_wait", CTRL_FLUSH);
    applyIdle();
    checkCtrl("to_t4_fallthrough", CTRL_RUN);
    checkOutput("br_cnt_8", br_stall_cnt, 16'd8);
    applyIdle();
    checkOutput("timeout_set", {15'd0, br_timeout}, 16'd1);
    checkCtrl("to_back_run", CTRL_RUN);
    applyIdle();
    checkOutput("timeout_sticky", {15'd0, br_timeout}, 16'd1);

    // Async reset mid-wait, then a late resolve must not be consumed.
    applyStimulus(1'b1, 6'h04, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
    applyIdle();
    checkCtrl("rw_t1_wait", CTRL_FLUSH);
    #2;
    rst = 1'b1;
    #1;
    checkCtrl("rw_forced_ctrl", CTRL_RST);
    checkOutput("rw_timeout_clr", {15'd0, br_timeout}, 16'd0);
    checkOutput("rw_lu_clr", lu_stall_cnt, 16'd0);
    checkOutput("rw_br_clr", br_stall_cnt, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    checkCtrl("rw_resolve_ignored", CTRL_RUN);

    // Saturation: hold a load-use hazard for 70000 cycles.
    applyStimulus(1'b1, 6'h00, 5'd7, 5'd1, 1'b1, 5'd7, 1'b0, 1'b0);
    repeat (70000) @(negedge clk);
    #1;
    checkOutput("lu_saturated", lu_stall_cnt, 16'hFFFF);
    checkCtrl("lu_sat_ctrl", CTRL_LU);
    repeat (5) @(negedge clk);
    #1;
    checkOutput("lu_sat_hold", lu_stall_cnt, 16'hFFFF);
    checkOutput("br_cnt_untouched", br_stall_cnt, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
